// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length constants, key-expansion FSM encoding,
// the GF(2^8) xtime helper and the forward S-box used by SubWord/SubBytes.
package aes_pkg;

  localparam int NK128  = 4;
  localparam int NK192  = 6;
  localparam int NK256  = 8;
  localparam int MAX_NR = 14;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word, combinational.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule, one 32-bit word per cycle into the flat bus w.
// Optional KEYEXP_SUBWORD_PIPE_EN registers the SubWord result (extra hold cycle).
module key_expansion_seq #(
  parameter int MAX_NR = aes_pkg::MAX_NR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [0:3]                    Nk,
  input  logic [0:255]                  key,
  output logic [0:(128*(MAX_NR+1))-1]   w,
  output logic [0:3]                    Nr,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);
  import aes_pkg::*;

  localparam int NW = 4 * (MAX_NR + 1);
  localparam int IW = $clog2(NW);

  state_t         state;
  logic [31:0]    words [NW];
  logic [0:255]   key_q;
  logic [3:0]     nk_q;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  last_idx;
  logic [3:0]     cnt;
  logic [7:0]     rcon;

  logic [3:0]     nk_in;
  logic [3:0]     nr_next;
  logic           nk_legal;
  logic [31:0]    prev;
  logic [31:0]    back;
  logic [31:0]    sub_in;
  logic [31:0]    sub_comb;
  logic [31:0]    sub_val;
  logic [31:0]    temp;
  logic           is_rot;
  logic           need_sub;
  logic           write_en;

`ifdef KEYEXP_SUBWORD_PIPE_EN
  logic [31:0]    sub_q;
  logic           sub_hold;
`endif

  assign nk_in    = Nk;
  assign nr_next  = nk_in + 4'd6;
  assign nk_legal = (nk_in == 4'(NK128)) || (nk_in == 4'(NK192)) || (nk_in == 4'(NK256));

  // cnt counts down from Nk, so cnt==Nk marks i mod Nk == 0 and, for Nk=8, cnt==4 marks i mod 8 == 4
  assign prev     = words[idx - IW'(1)];
  assign back     = words[idx - IW'(nk_q)];
  assign is_rot   = (cnt == nk_q);
  assign need_sub = is_rot || ((nk_q == 4'(NK256)) && (cnt == 4'd4));
  assign sub_in   = is_rot ? {prev[23:0], prev[31:24]} : prev;

  sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_comb)
  );

  always_comb begin
`ifdef KEYEXP_SUBWORD_PIPE_EN
    sub_val  = sub_q;
    write_en = !need_sub || sub_hold;
`else
    sub_val  = sub_comb;
    write_en = 1'b1;
`endif
    temp = prev;
    if (is_rot)        temp = sub_val ^ {rcon, 24'h0};
    else if (need_sub) temp = sub_val;
  end

  for (genvar g = 0; g < NW; g++) begin : g_w
    assign w[32*g +: 32] = words[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      for (int j = 0; j < NW; j++) words[j] <= '0;
      key_q    <= '0;
      nk_q     <= '0;
      idx      <= '0;
      last_idx <= '0;
      cnt      <= '0;
      rcon     <= 8'h01;
      Nr       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef KEYEXP_SUBWORD_PIPE_EN
      sub_q    <= '0;
      sub_hold <= 1'b0;
`endif
    end else begin
      error <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (nk_legal) begin
              nk_q     <= nk_in;
              key_q    <= key;
              Nr       <= nr_next;
              last_idx <= IW'({nr_next, 2'b11});
              for (int j = 0; j < NW; j++) words[j] <= '0;
              rcon     <= 8'h01;
              done     <= 1'b0;
              busy     <= 1'b1;
              state    <= LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          for (int j = 0; j < 8; j++) begin
            if (4'(j) < nk_q) words[j] <= key_q[32*j +: 32];
          end
          idx   <= IW'(nk_q);
          cnt   <= nk_q;
          state <= EXPAND;
        end
        EXPAND: begin
`ifdef KEYEXP_SUBWORD_PIPE_EN
          if (need_sub && !sub_hold) begin
            sub_q    <= sub_comb;
            sub_hold <= 1'b1;
          end else begin
            sub_hold <= 1'b0;
          end
`endif
          if (write_en) begin
            words[idx] <= back ^ temp;
            if (is_rot) rcon <= xtime(rcon);
            cnt <= (cnt == 4'd1) ? nk_q : cnt - 4'd1;
            idx <= idx + IW'(1);
            if (idx == last_idx) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
